booth_mul_sched: RTL and testbench

- Round-robin scheduler that shares one sequential 8-bit Booth multiplier core between NREQ requesters.
- Arbitrates requests and captures the winner's operands.
- Drives the core's start and serial operand bus: multiplicand first, then multiplier.
- Waits for the core's done flag, returns the 16-bit product with the requester ID, then clears the core for the next job.
- Timeout guard reports a hung core.

---
 rtl/booth_mul_sched.sv | 166 ++++++++++++++++
 tb/tb_booth_mul_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_sched.sv
// Round-robin front end that time-shares one sequential 8x8 Booth multiplier core
// between NREQ requesters, with a WAIT-state timeout guard against a hung core.
module booth_mul_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 mul_start,
    output logic [7:0]           mul_data,
    output logic                 mul_clr,
    input  logic                 mul_done,
    input  logic [15:0]          mul_product,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [15:0]          resp_product,
    output logic                 resp_err
);

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);
    localparam logic [IDW-1:0]  LastId     = IDW'(NREQ - 1);
    localparam logic [IDW:0]    NreqExt    = (IDW + 1)'(NREQ);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StLdM,
        StLdQ,
        StWait,
        StResp,
        StClr
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [7:0]      op_a_q, op_a_d;
    logic [7:0]      op_b_q, op_b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     prod_q, prod_d;
    logic            err_q, err_d;

    logic            found;
    logic [IDW-1:0]  win_id;
    logic [IDW:0]    idx;
    logic [CntW-1:0] cnt_inc;

    // Search starts at the RR pointer; ptr + i < 2*NREQ, so one subtract wraps it.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr_q} + (IDW + 1)'(i);
            if (idx >= NreqExt) begin
                idx = idx - NreqExt;
            end
            if (!found && req[idx[IDW-1:0]]) begin
                found  = 1'b1;
                win_id = idx[IDW-1:0];
            end
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    id_d    = win_id;
                    op_a_d  = req_a[8*win_id +: 8];
                    op_b_d  = req_b[8*win_id +: 8];
                    ptr_d   = (win_id == LastId) ? '0 : win_id + 1'b1;
                    state_d = StStart;
                end
            end
            StStart: state_d = StLdM;
            StLdM:   state_d = StLdQ;
            StLdQ: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_inc;
                // A done on the timeout cycle still wins: the product is real.
                if (mul_done) begin
                    prod_d  = mul_product;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_inc == TimeoutVal) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StClr;
            StClr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        busy         = (state_q != StIdle);
        mul_start    = (state_q == StStart);
        mul_clr      = (state_q == StClr);
        resp_valid   = (state_q == StResp);
        gnt          = '0;
        mul_data     = '0;
        resp_id      = '0;
        resp_product = '0;
        resp_err     = 1'b0;
        if (state_q == StStart) begin
            gnt = {{(NREQ - 1){1'b0}}, 1'b1} << id_q;
        end
        if (state_q == StLdM) begin
            mul_data = op_a_q;
        end else if (state_q == StLdQ) begin
            mul_data = op_b_q;
        end
        if (state_q == StResp) begin
            resp_id      = id_q;
            resp_product = prod_q;
            resp_err     = err_q;
        end
    end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched: behavioural multiplier core plus a response
// scoreboard filled as requests are raised and drained as responses appear.
module tb_booth_mul_sched;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned TIMEOUT = 31;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic                mul_start;
    logic [7:0]          mul_data;
    logic                mul_clr;
    logic                mul_done;
    logic [15:0]         mul_product;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [15:0]         resp_product;
    logic                resp_err;

    booth_mul_sched #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_a        (req_a),
        .req_b        (req_b),
        .gnt          (gnt),
        .busy         (busy),
        .mul_start    (mul_start),
        .mul_data     (mul_data),
        .mul_clr      (mul_clr),
        .mul_done     (mul_done),
        .mul_product  (mul_product),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: start, then multiplicand, then multiplier; done after core_lat
    // further cycles and held until clear. core_hang keeps done low forever.
    int         core_lat  = 3;
    bit         core_hang = 1'b0;
    logic [2:0] core_ph;
    logic [7:0] core_a, core_b;
    int         core_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ph     <= 3'd0;
            mul_done    <= 1'b0;
            mul_product <= 16'h0;
        end else if (mul_clr) begin
            core_ph  <= 3'd0;
            mul_done <= 1'b0;
        end else begin
            case (core_ph)
                3'd0: if (mul_start) core_ph <= 3'd1;
                3'd1: begin core_a <= mul_data; core_ph <= 3'd2; end
                3'd2: begin core_b <= mul_data; core_cnt <= core_lat; core_ph <= 3'd3; end
                3'd3: begin
                    if (!core_hang) begin
                        if (core_cnt == 0) begin
                            mul_done    <= 1'b1;
                            mul_product <= {{8{core_a[7]}}, core_a} * {{8{core_b[7]}}, core_b};
                            core_ph     <= 3'd4;
                        end else begin
                            core_cnt <= core_cnt - 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [IDW-1:0] id;
        logic [15:0]    prod;
        logic           err;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   gnt_cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    // lat = cycles from the grant (START) cycle to the RESP cycle: 3 + WAIT cycles.
    task automatic push_exp(input int id, input bit err, input int lat);
        exp_t e;
        e.id   = IDW'(id);
        e.err  = err;
        e.prod = err ? 16'h0 : smul(req_a[8*id +: 8], req_b[8*id +: 8]);
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
    endtask

    task automatic wait_grant(input int id, input string tag);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (gnt !== '0) break;
        end
        chk({tag, " gnt"}, 32'(gnt), 32'(1) << id);
        chk({tag, " start"}, 32'(mul_start), 32'd1);
        gnt_cyc = cyc;
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) break;
        end
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " resp_id"}, 32'(resp_id), 32'(e.id));
            chk({tag, " resp_product"}, 32'(resp_product), 32'(e.prod));
            chk({tag, " resp_err"}, 32'(resp_err), 32'(e.err));
            chk({tag, " latency"}, 32'(cyc - gnt_cyc), 32'(e.lat));
        end
        @(negedge clk);
        chk({tag, " clr"}, {30'd0, mul_clr, resp_valid}, 32'b10);
        @(negedge clk);
        chk({tag, " idle"}, {30'd0, busy, mul_clr}, 32'b00);
    endtask

    initial begin
        req   = '0;
        req_a = '0;
        req_b = '0;
        set_ops(0, 8'd7,  8'hFD);
        set_ops(1, 8'h12, 8'h34);
        set_ops(2, 8'hF0, 8'h05);
        set_ops(3, 8'h7F, 8'h81);
        #1 rst_n = 1'b0;
        #2;
        chk("reset ctl", {busy, gnt, mul_start, mul_clr, resp_valid, resp_err}, 32'd0);
        chk("reset data", {mul_data, resp_product}, 32'd0);
        chk("reset id", 32'(resp_id), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Round robin with everything held: 0,1,2,3,0.
        push_exp(0, 1'b0, 8); push_exp(1, 1'b0, 8); push_exp(2, 1'b0, 8);
        push_exp(3, 1'b0, 8); push_exp(0, 1'b0, 8);
        req = 4'b1111;
        wait_grant(0, "rr0"); wait_resp("rr0");
        wait_grant(1, "rr1"); wait_resp("rr1");
        wait_grant(2, "rr2"); wait_resp("rr2");
        wait_grant(3, "rr3"); wait_resp("rr3");
        wait_grant(0, "rr4"); req = '0; wait_resp("rr4");

        // Single job with operand bus sequence.
        push_exp(0, 1'b0, 8);
        req = 4'b0001;
        wait_grant(0, "single");
        req = '0;
        chk("single data0", 32'(mul_data), 32'h00);
        @(negedge clk);
        chk("single gnt1cyc", 32'(gnt), 32'd0);
        chk("single dataM", {23'd0, mul_start, mul_data}, 32'h007);
        @(negedge clk);
        chk("single dataQ", 32'(mul_data), 32'hFD);
        @(negedge clk);
        chk("single wait", {23'd0, busy, mul_data}, 32'h100);
        wait_resp("single");

        // Pointer wrap 3 -> 0, then lower ids in order.
        push_exp(3, 1'b0, 8);
        req = 4'b1000;
        wait_grant(3, "wrap3"); req = '0; wait_resp("wrap3");
        push_exp(0, 1'b0, 8); push_exp(1, 1'b0, 8);
        req = 4'b0011;
        wait_grant(0, "wrap0"); req[0] = 1'b0; wait_resp("wrap0");
        wait_grant(1, "wrap1"); req[1] = 1'b0; wait_resp("wrap1");
        push_exp(3, 1'b0, 8);
        req = 4'b1000;
        wait_grant(3, "pre_rot"); req = '0; wait_resp("pre_rot");

        // Rotation between slots 0 and 2 only.
        push_exp(0, 1'b0, 8); push_exp(2, 1'b0, 8);
        push_exp(0, 1'b0, 8); push_exp(2, 1'b0, 8);
        req = 4'b0101;
        wait_grant(0, "rot0"); wait_resp("rot0");
        wait_grant(2, "rot1"); wait_resp("rot1");
        wait_grant(0, "rot2"); wait_resp("rot2");
        wait_grant(2, "rot3"); req = '0; wait_resp("rot3");

        // Hung core: error response after exactly TIMEOUT WAIT cycles.
        core_hang = 1'b1;
        push_exp(1, 1'b1, 3 + TIMEOUT);
        req = 4'b0010;
        wait_grant(1, "timeout"); req = '0; wait_resp("timeout");
        core_hang = 1'b0;

        // Done on the very cycle the counter would expire.
        set_ops(2, 8'h80, 8'h80);
        core_lat = TIMEOUT - 2;
        push_exp(2, 1'b0, 3 + TIMEOUT);
        chk("simul model", 32'(sb[sb.size() - 1].prod), 32'h4000);
        req = 4'b0100;
        wait_grant(2, "simul"); req = '0; wait_resp("simul");
        core_lat = 3;

        // Reset during WAIT: outputs clear at once, job is dropped, pointer returns to 0.
        core_hang = 1'b1;
        req = 4'b0100;
        wait_grant(2, "abort");
        req = '0;
        repeat (8) @(negedge clk);
        chk("abort in wait", {23'd0, busy, mul_data}, 32'h100);
        #1 rst_n = 1'b0;
        #1;
        chk("abort ctl", {busy, gnt, mul_start, mul_clr, resp_valid, resp_err}, 32'd0);
        chk("abort data", {mul_data, resp_product}, 32'd0);
        @(negedge clk);
        chk("abort no resp", {31'd0, resp_valid}, 32'd0);
        core_hang = 1'b0;
        rst_n = 1'b1;
        push_exp(1, 1'b0, 8); push_exp(3, 1'b0, 8);
        req = 4'b1010;
        wait_grant(1, "post_rst1"); req[1] = 1'b0; wait_resp("post_rst1");
        wait_grant(3, "post_rst3"); req[3] = 1'b0; wait_resp("post_rst3");

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
